// File: rtl/splitter2_pan_pkg.sv
// rtl/splitter2_pan_pkg.sv - shared audio constants, FSM states and sample type for the panner
package splitter2_pan_pkg;
   localparam int SAMPLE_BITS = 16;
   localparam int GAIN_BITS   = 9;
   localparam int GAIN_SHIFT  = 8;
   localparam int MUL_CYCLES  = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic signed [SAMPLE_BITS-1:0] sample_t;

   // Channel-1 gain is the complement of pan against unity (256), so it spans 1..256.
   function automatic logic [GAIN_BITS-1:0] pan_to_gain1(input logic [7:0] pan);
      return 9'd256 - {1'b0, pan};
   endfunction
endpackage

// File: rtl/splitter2_pan_if.sv
// rtl/splitter2_pan_if.sv - frame strobe, sample/pan inputs and weighted outputs of the panner
interface splitter2_pan_if
   import splitter2_pan_pkg::*;
#(
   parameter int BITSIZE = SAMPLE_BITS
);
   logic                      lrclk;
   logic signed [BITSIZE-1:0] in;
   logic        [7:0]         pan;
   logic signed [BITSIZE-1:0] out1;
   logic signed [BITSIZE-1:0] out2;
   logic                      valid;
   logic                      overrun;

   modport master (
      output lrclk, in, pan,
      input  out1, out2, valid, overrun
   );

   modport slave (
      input  lrclk, in, pan,
      output out1, out2, valid, overrun
   );
endinterface

// File: rtl/splitter2_pan_mul.sv
// rtl/splitter2_pan_mul.sv - signed sample x unsigned 9-bit gain, LSB-first shift-add, one gain bit per clock
module serial_mul_s_u9
   import splitter2_pan_pkg::*;
#(
   parameter int BITSIZE = SAMPLE_BITS
) (
   input  logic                                i_clk,
   input  logic                                i_reset,
   input  logic                                i_start,
   input  logic signed [BITSIZE-1:0]           i_multiplicand,
   input  logic        [GAIN_BITS-1:0]         i_gain,
   output logic                                o_busy,
   output logic                                o_done,
   output logic signed [BITSIZE+GAIN_BITS-1:0] o_product
);
   localparam int ACC_W = BITSIZE + GAIN_BITS;

   logic signed [BITSIZE-1:0] r_a;
   logic        [GAIN_BITS-1:0] r_gain;
   logic signed [ACC_W-1:0]   r_acc;
   logic        [3:0]         r_k;
   logic                      r_busy;

   logic signed [ACC_W-1:0]   w_ext;
   logic signed [ACC_W-1:0]   w_addend;
   logic                      w_last;

   assign w_ext    = {{GAIN_BITS{r_a[BITSIZE-1]}}, r_a};
   assign w_addend = w_ext <<< r_k;
   // Final gain bit is being consumed; the product is complete after this edge.
   assign w_last   = r_busy && (r_k == 4'(MUL_CYCLES - 1));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_a    <= '0;
         r_gain <= '0;
         r_acc  <= '0;
         r_k    <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_a    <= i_multiplicand;
         r_gain <= i_gain;
         r_acc  <= '0;
         r_k    <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         if (r_gain[r_k]) begin
            r_acc <= r_acc + w_addend;
         end
         r_k <= r_k + 4'd1;
         if (w_last) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = w_last;
   assign o_product = r_acc;
endmodule

// File: rtl/splitter2_pan.sv
// rtl/splitter2_pan.sv - mono-to-two-channel panner: lrclk edge detect, FSM, two serial multipliers
module splitter2_pan
   import splitter2_pan_pkg::*;
#(
   parameter int BITSIZE = SAMPLE_BITS
) (
   input  logic           i_bclk,
   input  logic           i_reset,
   splitter2_pan_if.slave bus
);
   localparam int ACC_W = BITSIZE + GAIN_BITS;

   logic                      r_s1;
   logic                      r_s2;
   state_t                    r_state;
   state_t                    w_next;
   logic                      w_start;
   logic                      w_rise;
   logic                      w_busy;

   logic signed [BITSIZE-1:0] r_out1;
   logic signed [BITSIZE-1:0] r_out2;
   logic                      r_valid;
   logic                      r_overrun;

   logic [GAIN_BITS-1:0]      w_g1;
   logic [GAIN_BITS-1:0]      w_g2;
   logic                      w_busy1;
   logic                      w_busy2;
   logic                      w_done1;
   logic                      w_done2;
   logic signed [ACC_W-1:0]   w_prod1;
   logic signed [ACC_W-1:0]   w_prod2;

   assign w_rise = r_s1 & ~r_s2;
   assign w_g1   = pan_to_gain1(bus.pan);
   assign w_g2   = {1'b0, bus.pan};
   // DONE counts as busy so a rise coinciding with DONE->IDLE is dropped.
   assign w_busy = (r_state != IDLE) || w_busy1 || w_busy2;

   always_ff @(posedge i_bclk) begin
      if (i_reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= bus.lrclk;
         r_s2 <= r_s1;
      end
   end

   always_ff @(posedge i_bclk) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_start = 1'b1;
               w_next  = MUL;
            end
         end
         MUL: begin
            if (w_done1 && w_done2) begin
               w_next = DONE;
            end
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   serial_mul_s_u9 #(.BITSIZE(BITSIZE)) u_mul1 (
      .i_clk          (i_bclk),
      .i_reset        (i_reset),
      .i_start        (w_start),
      .i_multiplicand (bus.in),
      .i_gain         (w_g1),
      .o_busy         (w_busy1),
      .o_done         (w_done1),
      .o_product      (w_prod1)
   );

   serial_mul_s_u9 #(.BITSIZE(BITSIZE)) u_mul2 (
      .i_clk          (i_bclk),
      .i_reset        (i_reset),
      .i_start        (w_start),
      .i_multiplicand (bus.in),
      .i_gain         (w_g2),
      .o_busy         (w_busy2),
      .o_done         (w_done2),
      .o_product      (w_prod2)
   );

   always_ff @(posedge i_bclk) begin
      if (i_reset) begin
         r_out1    <= '0;
         r_out2    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_valid <= (r_state == DONE);
         if (r_state == DONE) begin
            // Gain never exceeds 256, so dropping the top bits after the shift loses nothing.
            r_out1 <= BITSIZE'(w_prod1 >>> GAIN_SHIFT);
            r_out2 <= BITSIZE'(w_prod2 >>> GAIN_SHIFT);
         end
         if (w_rise && w_busy) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign bus.out1    = r_out1;
   assign bus.out2    = r_out2;
   assign bus.valid   = r_valid;
   assign bus.overrun = r_overrun;
endmodule
